// File: rtl/watch_edit_if.sv
// rtl/watch_edit_if.sv - button/time bundle between the watch_edit editor and its host
interface watch_edit_if #(parameter int FIELD_W = 8);
  logic                   active;
  logic [3:0]             sw_in;
  logic [6*FIELD_W-1:0]   time_in;
  logic [6*FIELD_W-1:0]   bin_time;
  logic                   en_time;
  logic [2:0]             cursor;
  logic                   editing;

  modport master (output active, sw_in, time_in, input bin_time, en_time, cursor, editing);
  modport slave  (input active, sw_in, time_in, output bin_time, en_time, cursor, editing);
endinterface

// File: rtl/watch_edit.sv
// rtl/watch_edit.sv - button-driven editor for a {year,month,day,hour,minute,second} time buffer
// Optional WATCH_EDIT_MONTHDAY_EN: month/leap-year dependent day limit with day clamping.
module watch_edit #(
  parameter int FIELD_W = 8,
  parameter int RPT_DLY = 16,
  parameter int RPT_PER = 4
) (
  input  logic          clk,
  input  logic          rst,
  watch_edit_if.slave   bus
);
  localparam int CW = $clog2(RPT_DLY + RPT_PER + 1) + 1;

  typedef logic [FIELD_W-1:0] fld_t;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t              state, state_n;
  logic                act_q;
  logic [3:0]          sw_q;
  logic [5:0][FIELD_W-1:0] buf_q, buf_n;
  logic [2:0]          cur_q, cur_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic                armed_q, armed_n;
  logic                act_rise, sw_live, inc_only, dec_only, first, step, move_l, move_r;
  logic [3:0]          sw_rise;
  fld_t                cur_v, new_v, mn, mx;

  assign act_rise = bus.active & ~act_q;
  assign sw_rise  = bus.sw_in & ~sw_q;
  assign sw_live  = (state == EDIT) & ~act_rise;
  assign inc_only = bus.sw_in[2] & ~bus.sw_in[3];
  assign dec_only = bus.sw_in[3] & ~bus.sw_in[2];
  assign first    = inc_only ? ~sw_q[2] : ~sw_q[3];
  assign move_l   = sw_rise[0] & ~sw_rise[1];
  assign move_r   = sw_rise[1] & ~sw_rise[0];

`ifdef WATCH_EDIT_MONTHDAY_EN
  function automatic fld_t day_max(fld_t month, fld_t year);
    if (month == fld_t'(2))
      return (year[1:0] == 2'd0) ? fld_t'(29) : fld_t'(28);
    if (month == fld_t'(4) || month == fld_t'(6) || month == fld_t'(9) || month == fld_t'(11))
      return fld_t'(30);
    return fld_t'(31);
  endfunction
`endif

  // Auto-repeat: first step on the press, then after RPT_DLY held cycles, then every RPT_PER.
  always_comb begin
    cnt_n   = '0;
    armed_n = 1'b0;
    step    = 1'b0;
    if (sw_live && (inc_only || dec_only)) begin
      if (first) begin
        step = 1'b1;
      end else if (!armed_q) begin
        if (cnt_q == CW'(RPT_DLY)) begin
          step    = 1'b1;
          armed_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end else begin
        armed_n = 1'b1;
        if (cnt_q == CW'(RPT_PER - 1)) step = 1'b1;
        else                           cnt_n = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_v = buf_q[cur_q];
    mn    = fld_t'(0);
    mx    = fld_t'(59);
    case (cur_q)
      3'd2: mx = fld_t'(23);
      3'd3: begin
        mn = fld_t'(1);
`ifdef WATCH_EDIT_MONTHDAY_EN
        mx = day_max(buf_q[4], buf_q[5]);
`else
        mx = fld_t'(31);
`endif
      end
      3'd4: begin
        mn = fld_t'(1);
        mx = fld_t'(12);
      end
      3'd5: mx = fld_t'(99);
      default: ;
    endcase
    // Out-of-range loads snap to max; wraps come from compares, never from overflow.
    if (cur_v > mx)    new_v = mx;
    else if (inc_only) new_v = (cur_v == mx) ? mn : cur_v + 1'b1;
    else               new_v = (cur_v <= mn) ? mx : cur_v - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
`ifdef WATCH_EDIT_MONTHDAY_EN
    fld_t dm;
    dm = fld_t'(31);
`endif
    state_n     = state;
    buf_n       = buf_q;
    cur_n       = cur_q;
    bus.editing = 1'b0;
    bus.en_time = 1'b0;
    case (state)
      IDLE: begin
        if (act_rise) begin
          state_n = EDIT;
          buf_n   = bus.time_in;
          cur_n   = 3'd0;
        end
      end
      EDIT: begin
        bus.editing = 1'b1;
        if (act_rise) begin
          state_n = COMMIT;
        end else if (move_r) begin
          cur_n = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;
        end else if (move_l) begin
          cur_n = (cur_q == 3'd0) ? 3'd5 : cur_q - 3'd1;
        end else if (step) begin
          buf_n[cur_q] = new_v;
`ifdef WATCH_EDIT_MONTHDAY_EN
          if (cur_q == 3'd4 || cur_q == 3'd5) begin
            dm = day_max(buf_n[4], buf_n[5]);
            if (buf_n[3] > dm) buf_n[3] = dm;
          end
`endif
        end
      end
      COMMIT: begin
        bus.en_time = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q   <= 1'b0;
      sw_q    <= 4'd0;
      buf_q   <= '0;
      cur_q   <= 3'd0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      act_q   <= bus.active;
      sw_q    <= bus.sw_in;
      buf_q   <= buf_n;
      cur_q   <= cur_n;
      cnt_q   <= cnt_n;
      armed_q <= armed_n;
    end
  end

  assign bus.bin_time = buf_q;
  assign bus.cursor   = cur_q;
endmodule

// File: tb/tb_watch_edit.sv
// tb/tb_watch_edit.sv - randomized scoreboard bench for watch_edit with a field-rule reference model
`timescale 1ns/1ps
module tb_watch_edit;
  localparam int W       = 8;
  localparam int RPT_DLY = 16;
  localparam int RPT_PER = 4;
`ifdef WATCH_EDIT_MONTHDAY_EN
  localparam int DAY23 = 28;
  localparam int DAY24 = 29;
`else
  localparam int DAY23 = 31;
  localparam int DAY24 = 31;
`endif

  typedef logic [6*W-1:0] tv_t;
  typedef struct packed {
    tv_t        bt;
    logic [2:0] cur;
    logic       ed;
    logic       en;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  watch_edit_if #(.FIELD_W(W)) bus();
  watch_edit #(.FIELD_W(W), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  tv_t   com_q[$];

  // Reference model: six integer fields, cursor, mode flags and hold length.
  int       f[6];
  int       m_cur;
  bit       m_edit, m_commit;
  int       k;
  bit       p_act;
  bit [3:0] p_sw;

  function automatic tv_t pack6(int yr, int mo, int dy, int hr, int mi, int se);
    return {W'(yr), W'(mo), W'(dy), W'(hr), W'(mi), W'(se)};
  endfunction

  function automatic tv_t pack_model();
    return pack6(f[5], f[4], f[3], f[2], f[1], f[0]);
  endfunction

  function automatic int fld(tv_t t, int i);
    return int'(t[i*W +: W]);
  endfunction

  function automatic int dmax(int mo, int yr);
`ifdef WATCH_EDIT_MONTHDAY_EN
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
`else
    if (mo < 0 || yr < 0) return 0;
    return 31;
`endif
  endfunction

  task automatic apply_step(bit up);
    int mn, mx, v;
    mn = (m_cur == 3 || m_cur == 4) ? 1 : 0;
    case (m_cur)
      0, 1:    mx = 59;
      2:       mx = 23;
      3:       mx = dmax(f[4], f[5]);
      4:       mx = 12;
      default: mx = 99;
    endcase
    v = f[m_cur];
    if (v > mx)  v = mx;
    else if (up) v = (v == mx) ? mn : v + 1;
    else         v = (v <= mn) ? mx : v - 1;
    f[m_cur] = v;
`ifdef WATCH_EDIT_MONTHDAY_EN
    if (m_cur >= 4 && f[3] > dmax(f[4], f[5])) f[3] = dmax(f[4], f[5]);
`endif
  endtask

  task automatic model_step(bit a, bit [3:0] s, bit r);
    bit arise, live, up, dn, held, stp, moved;
    bit [3:0] rs;
    if (!r) begin
      for (int i = 0; i < 6; i++) f[i] = 0;
      m_cur = 0; m_edit = 0; m_commit = 0; k = 0; p_act = 0; p_sw = 0;
      return;
    end
    arise = a && !p_act;
    rs    = s & ~p_sw;
    live  = 0;
    if (m_commit) begin
      m_commit = 0;
    end else if (!m_edit) begin
      if (arise) begin
        for (int i = 0; i < 6; i++) f[i] = fld(bus.time_in, i);
        m_cur  = 0;
        m_edit = 1;
      end
    end else if (arise) begin
      m_edit   = 0;
      m_commit = 1;
      com_q.push_back(pack_model());
    end else begin
      live = 1;
    end
    if (live) begin
      up  = s[2] && !s[3];
      dn  = s[3] && !s[2];
      stp = 0;
      if (up || dn) begin
        held = up ? p_sw[2] : p_sw[3];
        if (!held) begin
          k   = 0;
          stp = 1;
        end else begin
          k++;
          stp = (k > RPT_DLY) && ((k - RPT_DLY - 1) % RPT_PER == 0);
        end
      end else begin
        k = 0;
      end
      moved = rs[0] ^ rs[1];
      if (rs[1] && !rs[0]) m_cur = (m_cur + 1) % 6;
      if (rs[0] && !rs[1]) m_cur = (m_cur + 5) % 6;
      if (stp && !moved) apply_step(up);
    end else begin
      k = 0;
    end
    p_act = a;
    p_sw  = s;
  endtask

  task automatic tick(bit a, bit [3:0] s, bit r);
    snap_t e;
    @(negedge clk);
    bus.active = a;
    bus.sw_in  = s;
    rst        = r;
    model_step(a, s, r);
    e.bt  = pack_model();
    e.cur = 3'(m_cur);
    e.ed  = m_edit;
    e.en  = m_commit;
    exp_q.push_back(e);
  endtask

  task automatic press(bit [3:0] s);
    tick(1'b0, s, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
  endtask

  task automatic toggle_active();
    tick(1'b1, 4'd0, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int rfield(int lo, int hi);
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 255));
    return int'($urandom_range(hi, lo));
  endfunction

  // Monitor: compares every registered output against the scoreboard, and each commit pulse.
  initial begin
    snap_t e, g;
    tv_t   c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.bin_time, bus.cursor, bus.editing, bus.en_time};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL snapshot @%0t: got bin_time=%h cursor=%0d editing=%b en_time=%b expected bin_time=%h cursor=%0d editing=%b en_time=%b",
                   $time, g.bt, g.cur, g.ed, g.en, e.bt, e.cur, e.ed, e.en);
        end
      end
      if (bus.en_time === 1'b1) begin
        checks++;
        if (com_q.size() == 0) begin
          errors++;
          $display("FAIL commit_pulse @%0t: got unexpected en_time, expected none", $time);
        end else begin
          c = com_q.pop_front();
          if (bus.bin_time !== c) begin
            errors++;
            $display("FAIL commit_value @%0t: got %h expected %h", $time, bus.bin_time, c);
          end
        end
      end
    end
  end

  initial begin
    bit       a, r;
    bit [3:0] s;
    rst = 1'b0; bus.active = 1'b0; bus.sw_in = 4'd0; bus.time_in = '0;
    tick(1'b0, 4'd0, 1'b0);
    tick(1'b0, 4'd0, 1'b0);
    chk("rst_bin_time", bus.bin_time, 0);
    chk("rst_cursor", bus.cursor, 0);
    chk("rst_editing", bus.editing, 0);
    chk("rst_en_time", bus.en_time, 0);
    tick(1'b0, 4'd0, 1'b1);

    // Entry and commit.
    bus.time_in = pack6(24, 2, 28, 23, 59, 59);
    toggle_active();
    chk("entry_editing", bus.editing, 1);
    toggle_active();
    chk("commit_en_time", bus.en_time, 1);
    chk("commit_bin_time", bus.bin_time, pack6(24, 2, 28, 23, 59, 59));
    tick(1'b0, 4'd0, 1'b1);
    chk("commit_one_cycle", bus.en_time, 0);

    // Second wrap and cursor wrap.
    toggle_active();
    press(4'b0100);
    chk("second_wrap", fld(bus.bin_time, 0), 0);
    press(4'b0001);
    chk("cursor_wrap_left", bus.cursor, 5);
    press(4'b0010);
    chk("cursor_wrap_right", bus.cursor, 0);
    toggle_active();

    // Auto-repeat on minute.
    bus.time_in = pack6(24, 2, 28, 23, 10, 0);
    tick(1'b0, 4'd0, 1'b1);
    toggle_active();
    press(4'b0010);
    repeat (1 + RPT_DLY + 2*RPT_PER) tick(1'b0, 4'b0100, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
    chk("auto_repeat_minute", fld(bus.bin_time, 1), 13);
    repeat (6) tick(1'b0, 4'b1100, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
    chk("inc_dec_together", fld(bus.bin_time, 1), 13);
    press(4'b1000);
    chk("minute_dec", fld(bus.bin_time, 1), 12);
    toggle_active();

    // Month change against a day of 31, common and leap year.
    bus.time_in = pack6(23, 1, 31, 0, 0, 0);
    tick(1'b0, 4'd0, 1'b1);
    toggle_active();
    press(4'b0001);
    press(4'b0001);
    press(4'b0100);
    chk("month_to_feb", fld(bus.bin_time, 4), 2);
    chk("day_feb_y23", fld(bus.bin_time, 3), DAY23);
    toggle_active();
    bus.time_in = pack6(24, 1, 31, 0, 0, 0);
    tick(1'b0, 4'd0, 1'b1);
    toggle_active();
    press(4'b0001);
    press(4'b0001);
    press(4'b0100);
    chk("day_feb_y24", fld(bus.bin_time, 3), DAY24);
    toggle_active();

    // Reset in the middle of an hour edit.
    bus.time_in = pack6(24, 2, 28, 23, 59, 59);
    tick(1'b0, 4'd0, 1'b1);
    toggle_active();
    press(4'b0010);
    press(4'b0010);
    repeat (6) press(4'b0100);
    chk("hour_edit", fld(bus.bin_time, 2), 5);
    tick(1'b0, 4'd0, 1'b0);
    tick(1'b0, 4'd0, 1'b0);
    chk("midedit_rst_bin", bus.bin_time, 0);
    chk("midedit_rst_cursor", bus.cursor, 0);
    chk("midedit_rst_editing", bus.editing, 0);
    tick(1'b0, 4'd0, 1'b1);
    toggle_active();
    chk("post_rst_entry", bus.editing, 1);
    chk("post_rst_load", bus.bin_time, pack6(24, 2, 28, 23, 59, 59));

    // Random traffic.
    a = 1'b0;
    s = 4'd0;
    for (int n = 0; n < 2500; n++) begin
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0)
        bus.time_in = pack6(rfield(0, 99), rfield(1, 12), rfield(1, 31),
                            rfield(0, 23), rfield(0, 59), rfield(0, 59));
      tick(a, s, r);
    end

    tick(1'b0, 4'd0, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("commits_drained", com_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/watch_edit.md
WATCH_EDIT -- requirements
Module: watch_edit

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL take parameter FIELD_W, default 8, giving the width of each time field (minimum 7).
REQ-002 The block SHALL take parameter RPT_DLY, default 16, giving the hold cycles before inc/dec auto-repeat starts.
REQ-003 The block SHALL take parameter RPT_PER, default 4, giving the cycles between auto-repeat steps.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port active, input, 1, level; each rising edge toggles edit entry/commit.
REQ-007 The block SHALL have port sw_in, input, 4, level buttons: [0] cursor left, [1] cursor right, [2] increment, [3] decrement.
REQ-008 The block SHALL have port time_in, input, 6*FIELD_W, live time {year,month,day,hour,minute,second}, with second in the LSBs.
REQ-009 The block SHALL have port bin_time, output, 6*FIELD_W, edit buffer in the same packing as time_in.
REQ-010 The block SHALL have port en_time, output, 1, one-cycle commit strobe.
REQ-011 The block SHALL have port cursor, output, 3, selected field index (0=second .. 5=year).
REQ-012 The block SHALL have port editing, output, 1, high while in EDIT.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, EDIT and COMMIT.
REQ-014 Every input SHALL act on its rising edge, detected against a one-cycle registered copy; levels alone SHALL have no effect.
REQ-015 In IDLE, an active rise SHALL load time_in into bin_time, set cursor to 0 and enter EDIT on the next cycle.
REQ-016 In EDIT, an active rise SHALL enter COMMIT; COMMIT SHALL assert en_time for exactly one cycle and then return to IDLE.
REQ-017 A cursor-right rise SHALL wrap 5->0, and a cursor-left rise SHALL wrap 0->5; cursor SHALL never exceed 5.
REQ-018 Field ranges SHALL be: second 0-59, minute 0-59, hour 0-23, day 1-DMAX, month 1-12, year 0-99.
REQ-019 Increment SHALL wrap max->min, and decrement SHALL wrap min->max, for the field under cursor only.
REQ-020 Holding inc or dec alone SHALL step once on the rise, again after RPT_DLY cycles, then every RPT_PER cycles until release.
REQ-021 Simultaneous inc and dec SHALL cause no change and SHALL reset the repeat counter.
REQ-022 Simultaneous left and right SHALL cause no cursor move.
REQ-023 A cursor move SHALL take priority over inc/dec in the same cycle, so no field changes that cycle.
REQ-024 An active rise SHALL take priority over all sw_in events in the same cycle.
REQ-025 sw_in SHALL be ignored outside EDIT, and bin_time SHALL hold its value in IDLE and COMMIT.
REQ-026 A loaded field above its range SHALL clamp to its max on the first inc/dec touching that field.
REQ-027 Field arithmetic SHALL be unsigned FIELD_W-bit, with wrap decided by compare and never by overflow.

Reset
REQ-028 While rst is low, the block SHALL enter IDLE with bin_time=0, en_time=0, cursor=0, editing=0, repeat counter=0 and edge registers=0.
REQ-029 Reset during EDIT SHALL discard edits with no en_time pulse, and the first active rise after release SHALL be treated as an IDLE entry.

Configuration
REQ-030 With macro WATCH_EDIT_MONTHDAY_EN defined, DMAX SHALL be month-dependent (31/30/28, or 29 when year%4==0).
REQ-031 With WATCH_EDIT_MONTHDAY_EN defined, a month or year change SHALL clamp day to the new DMAX in the same cycle.
REQ-032 Without WATCH_EDIT_MONTHDAY_EN, DMAX SHALL be fixed at 31 with no clamping.

Verification
REQ-033 Entry/commit: time_in={24,2,28,23,59,59}, active rise -> editing=1 after 1 cycle; second active rise -> en_time high 1 cycle, bin_time equal to time_in.
REQ-034 Wrap: cursor=0, second=59, inc rise -> second=0; cursor=0, left rise -> cursor=5.
REQ-035 Auto-repeat: hold inc for 1+RPT_DLY+2*RPT_PER cycles on minute=10 -> minute=13; inc+dec together -> no change.
REQ-036 Month/day (macro on): day=31, month=1, set month to 2 with year=23 -> day=28; with year=24 -> day=29.
REQ-037 Macro off: the same sequence -> day stays 31.
REQ-038 Reset mid-edit: edit hour to 5, pull rst low -> bin_time=0, cursor=0, editing=0, en_time never pulses.
